apb_master_bridge_n: RTL and testbench

- Parametrised next-generation APB master bridge: converts a valid/ready request port into APB transfers to NUM_SLAVES slaves.
- Adds over the previous bridge: generic address/data widths, byte strobes, N-way one-hot decode, PREADY timeout, and a registered response channel carrying read data and error status.
- Sits between the system-side command source and the APB slave fabric.

---
 rtl/apb_master_bridge_n.sv | 269 ++++++++++++++++++++++++++
 tb/tb_apb_master_bridge_n.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge_n.sv
// ----------------------------------------------------------------------------
// apb_master_bridge_n
//
// Purpose:
//   Converts a valid/ready request port into APB transfers to one of
//   NUM_SLAVES slaves. The top SEL_BITS address bits pick the slave. An
//   out-of-range index is answered with a decode error and no bus activity.
//   A slave holding PREADY low for TIMEOUT_CYCLES access cycles is abandoned
//   and answered with a timeout error (TIMEOUT_CYCLES = 0 disables this).
//   Each finished transfer produces one registered single-cycle response.
//
// Ports:
//   PCLK, PRESET          clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake, accepted only in IDLE
//   req_write/req_addr    direction and address of the request
//   req_wdata/req_strb    write data and byte strobes
//   rsp_valid             one-cycle response pulse, no backpressure
//   rsp_rdata             read data (0 for writes and errors)
//   rsp_err/rsp_timeout   error flag and "error was a timeout" flag
//   PSEL..PSTRB           APB master outputs, all registered
//   PRDATA/PREADY/PSLVERR per-slave APB inputs, only the selected slave is used
// ----------------------------------------------------------------------------
module apb_master_bridge_n #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_SLAVES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_strb,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int SEL_BITS   = $clog2(NUM_SLAVES);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    // Counter value seen on the last allowed wait cycle; the increment taken
    // on that cycle would make the counter reach TIMEOUT_CYCLES.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SEL_BITS:0] NUM_SL = (SEL_BITS + 1)'(NUM_SLAVES);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    // Registered outputs and their next values
    logic [NUM_SLAVES-1:0] r_psel,     w_psel_nxt;
    logic                  r_penable,  w_penable_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr,    w_paddr_nxt;
    logic                  r_pwrite,   w_pwrite_nxt;
    logic [DATA_WIDTH-1:0] r_pwdata,   w_pwdata_nxt;
    logic [STRB_WIDTH-1:0] r_pstrb,    w_pstrb_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic                  r_rsp_err,   w_rsp_err_nxt;
    logic                  r_rsp_to,    w_rsp_to_nxt;
    logic [CNT_WIDTH-1:0]  r_wait_cnt,  w_wait_cnt_nxt;

    logic                  w_accept;
    logic [SEL_BITS-1:0]   w_idx;
    logic                  w_dec_ok;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_sel_ready;
    logic                  w_sel_err;
    logic [DATA_WIDTH-1:0] w_sel_rdata;
    logic                  w_timeout_hit;

    // ------------------------------------------------------------------------
    // Request decode and selected-slave return path
    // ------------------------------------------------------------------------
    assign req_ready = (r_state == StIdle) && !PRESET;
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign w_dec_ok  = ({1'b0, w_idx} < NUM_SL);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_onehot[i] = (w_idx == SEL_BITS'(i));
        end
    end

    // r_psel is one-hot during a transfer, so masking picks the live slave.
    assign w_sel_ready = |(PREADY & r_psel);
    assign w_sel_err   = |(PSLVERR & r_psel);

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_psel[i]) begin
                w_sel_rdata = w_sel_rdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_timeout_hit = TIMEOUT_EN && !w_sel_ready && (r_wait_cnt == CNT_LAST);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept && w_dec_ok) begin
                    w_state_nxt = StSetup;
                end
            end
            StSetup: begin
                w_state_nxt = StAccess;
            end
            StAccess: begin
                // Completion and timeout both return to IDLE
                if (w_sel_ready || w_timeout_hit) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------------
    always_comb begin
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_to_nxt    = r_rsp_to;
        w_wait_cnt_nxt  = r_wait_cnt;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_dec_ok) begin
                        w_psel_nxt   = w_onehot;
                        w_paddr_nxt  = req_addr;
                        w_pwrite_nxt = req_write;
                        w_pwdata_nxt = req_wdata;
                        w_pstrb_nxt  = req_write ? req_strb : '0;
                    end else begin
                        // Decode error: answer directly without touching the bus
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_to_nxt    = 1'b0;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end
            StSetup: begin
                w_penable_nxt  = 1'b1;
                w_wait_cnt_nxt = '0;
            end
            StAccess: begin
                if (w_sel_ready) begin
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_sel_err;
                    w_rsp_to_nxt    = 1'b0;
                    w_rsp_rdata_nxt = (!r_pwrite && !w_sel_err) ? w_sel_rdata : '0;
                end else begin
                    if (TIMEOUT_EN) begin
                        w_wait_cnt_nxt = r_wait_cnt + CNT_WIDTH'(1);
                    end
                    if (w_timeout_hit) begin
                        w_psel_nxt      = '0;
                        w_penable_nxt   = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_to_nxt    = 1'b1;
                        w_rsp_rdata_nxt = '0;
                    end
                end
            end
            default: begin
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_to    <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_to    <= w_rsp_to_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PADDR       = r_paddr;
    assign PWRITE      = r_pwrite;
    assign PWDATA      = r_pwdata;
    assign PSTRB       = r_pstrb;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_apb_master_bridge_n.sv
// ----------------------------------------------------------------------------
// tb_apb_master_bridge_n
//
// Two bridges share clock and reset: "a" has 2 slaves, "b" has 3 slaves (so
// index 3 is a decode error). Both use TIMEOUT_CYCLES = 4. Expected responses
// are queued when a request is driven and checked, including latency, when
// rsp_valid appears.
// ----------------------------------------------------------------------------
module tb_apb_master_bridge_n;

    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic       err;
        logic       to;
        logic [7:0] rdata;
        int         lat;
        int         acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    // Bridge "a": 2 slaves
    logic        a_req_valid = 0, a_req_ready, a_req_write = 0;
    logic [8:0]  a_req_addr = 0;
    logic [7:0]  a_req_wdata = 0;
    logic [0:0]  a_req_strb = 0;
    logic        a_rsp_valid, a_rsp_err, a_rsp_timeout;
    logic [7:0]  a_rsp_rdata;
    logic [1:0]  a_PSEL;
    logic        a_PENABLE, a_PWRITE;
    logic [8:0]  a_PADDR;
    logic [7:0]  a_PWDATA;
    logic [0:0]  a_PSTRB;
    logic [15:0] a_PRDATA = 0;
    logic [1:0]  a_PREADY = 0, a_PSLVERR = 0;

    // Bridge "b": 3 slaves
    logic        b_req_valid = 0, b_req_ready, b_req_write = 0;
    logic [8:0]  b_req_addr = 0;
    logic [7:0]  b_req_wdata = 0;
    logic [0:0]  b_req_strb = 0;
    logic        b_rsp_valid, b_rsp_err, b_rsp_timeout;
    logic [7:0]  b_rsp_rdata;
    logic [2:0]  b_PSEL;
    logic        b_PENABLE, b_PWRITE;
    logic [8:0]  b_PADDR;
    logic [7:0]  b_PWDATA;
    logic [0:0]  b_PSTRB;
    logic [23:0] b_PRDATA = 0;
    logic [2:0]  b_PREADY = 0, b_PSLVERR = 0;

    apb_master_bridge_n #(
        .ADDR_WIDTH(9), .DATA_WIDTH(8), .NUM_SLAVES(2), .TIMEOUT_CYCLES(4)
    ) u_dut_a (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_strb(a_req_strb),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .rsp_timeout(a_rsp_timeout),
        .PSEL(a_PSEL), .PENABLE(a_PENABLE), .PADDR(a_PADDR), .PWRITE(a_PWRITE),
        .PWDATA(a_PWDATA), .PSTRB(a_PSTRB),
        .PRDATA(a_PRDATA), .PREADY(a_PREADY), .PSLVERR(a_PSLVERR)
    );

    apb_master_bridge_n #(
        .ADDR_WIDTH(9), .DATA_WIDTH(8), .NUM_SLAVES(3), .TIMEOUT_CYCLES(4)
    ) u_dut_b (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_strb(b_req_strb),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .rsp_timeout(b_rsp_timeout),
        .PSEL(b_PSEL), .PENABLE(b_PENABLE), .PADDR(b_PADDR), .PWRITE(b_PWRITE),
        .PWDATA(b_PWDATA), .PSTRB(b_PSTRB),
        .PRDATA(b_PRDATA), .PREADY(b_PREADY), .PSLVERR(b_PSLVERR)
    );

    // Scoreboard monitors, sampled on the falling edge
    always @(negedge PCLK) begin
        if (a_rsp_valid) begin
            n_chk++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected_rsp got err=%b to=%b rdata=%h at cyc %0d",
                         a_rsp_err, a_rsp_timeout, a_rsp_rdata, cyc);
            end else begin
                ea = qa.pop_front();
                if ({a_rsp_err, a_rsp_timeout, a_rsp_rdata} !== {ea.err, ea.to, ea.rdata} ||
                    (cyc - ea.acc) != ea.lat) begin
                    n_err++;
                    $display("FAIL a_rsp got err=%b to=%b rdata=%h lat=%0d exp err=%b to=%b rdata=%h lat=%0d",
                             a_rsp_err, a_rsp_timeout, a_rsp_rdata, cyc - ea.acc,
                             ea.err, ea.to, ea.rdata, ea.lat);
                end
            end
        end
    end

    always @(negedge PCLK) begin
        if (b_rsp_valid) begin
            n_chk++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected_rsp got err=%b to=%b rdata=%h at cyc %0d",
                         b_rsp_err, b_rsp_timeout, b_rsp_rdata, cyc);
            end else begin
                eb = qb.pop_front();
                if ({b_rsp_err, b_rsp_timeout, b_rsp_rdata} !== {eb.err, eb.to, eb.rdata} ||
                    (cyc - eb.acc) != eb.lat) begin
                    n_err++;
                    $display("FAIL b_rsp got err=%b to=%b rdata=%h lat=%0d exp err=%b to=%b rdata=%h lat=%0d",
                             b_rsp_err, b_rsp_timeout, b_rsp_rdata, cyc - eb.acc,
                             eb.err, eb.to, eb.rdata, eb.lat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive_a(input logic w, input logic [8:0] addr, input logic [7:0] d,
                           input logic s);
        a_req_valid = 1'b1;
        a_req_write = w;
        a_req_addr  = addr;
        a_req_wdata = d;
        a_req_strb  = s;
    endtask

    task automatic drive_b(input logic w, input logic [8:0] addr, input logic [7:0] d,
                           input logic s);
        b_req_valid = 1'b1;
        b_req_write = w;
        b_req_addr  = addr;
        b_req_wdata = d;
        b_req_strb  = s;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        tick();
        tick();
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_PADDR, a_PWRITE, a_PWDATA, a_PSTRB, a_rsp_valid,
             a_rsp_err, a_rsp_timeout, a_rsp_rdata, a_req_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_a_outputs got psel=%b pen=%b paddr=%h rsp_v=%b rdy=%b exp all 0",
                     a_PSEL, a_PENABLE, a_PADDR, a_rsp_valid, a_req_ready);
        end
        n_chk++;
        if ({b_PSEL, b_PENABLE, b_PADDR, b_rsp_valid, b_rsp_err, b_req_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_b_outputs got psel=%b pen=%b paddr=%h rsp_v=%b rdy=%b exp all 0",
                     b_PSEL, b_PENABLE, b_PADDR, b_rsp_valid, b_req_ready);
        end
        PRESET = 1'b0;
        #1;
        n_chk++;
        if ({a_req_ready, b_req_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_release_ready got %b exp 11", {a_req_ready, b_req_ready});
        end
    endtask

    task automatic test_write_zero_wait();
        drive_a(1'b1, 9'h105, 8'hA5, 1'b1);
        n_chk++;
        if (a_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_ready got %b exp 1", a_req_ready);
        end
        qa.push_back('{1'b0, 1'b0, 8'h00, 3, cyc});
        tick();
        a_req_valid = 1'b0;
        a_req_wdata = 8'h00;  // late change must not reach PWDATA
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_PWRITE, a_PADDR, a_PWDATA, a_PSTRB, a_req_ready} !==
            {2'b10, 1'b0, 1'b1, 9'h105, 8'hA5, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL wr_setup got psel=%b pen=%b pw=%b paddr=%h pwd=%h strb=%b rdy=%b exp 10 0 1 105 a5 1 0",
                     a_PSEL, a_PENABLE, a_PWRITE, a_PADDR, a_PWDATA, a_PSTRB, a_req_ready);
        end
        a_PREADY = 2'b10;
        tick();
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_PWDATA} !== {2'b10, 1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL wr_access got psel=%b pen=%b pwd=%h exp 10 1 a5",
                     a_PSEL, a_PENABLE, a_PWDATA);
        end
        tick();
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_rsp_valid} !== {2'b00, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL wr_done got psel=%b pen=%b rsp_v=%b exp 00 0 1",
                     a_PSEL, a_PENABLE, a_rsp_valid);
        end
        a_PREADY = 2'b00;
    endtask

    task automatic test_read_wait();
        a_PRDATA = {8'hFF, 8'h3C};
        a_PREADY = 2'b10;  // unselected slave ready must be ignored
        drive_a(1'b0, 9'h010, 8'h11, 1'b1);
        qa.push_back('{1'b0, 1'b0, 8'h3C, 5, cyc});
        tick();
        a_req_valid = 1'b0;
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_PWRITE, a_PADDR, a_PSTRB} !==
            {2'b01, 1'b0, 1'b0, 9'h010, 1'b0}) begin
            n_err++;
            $display("FAIL rd_setup got psel=%b pen=%b pw=%b paddr=%h strb=%b exp 01 0 0 010 0",
                     a_PSEL, a_PENABLE, a_PWRITE, a_PADDR, a_PSTRB);
        end
        tick();
        tick();
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_rsp_valid} !== {2'b01, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL rd_waiting got psel=%b pen=%b rsp_v=%b exp 01 1 0",
                     a_PSEL, a_PENABLE, a_rsp_valid);
        end
        tick();
        a_PREADY = 2'b11;
        tick();
        n_chk++;
        if ({a_PSEL, a_rsp_valid} !== {2'b00, 1'b1}) begin
            n_err++;
            $display("FAIL rd_done got psel=%b rsp_v=%b exp 00 1", a_PSEL, a_rsp_valid);
        end
        a_PREADY = 2'b00;
    endtask

    task automatic test_slave_error_b2b();
        a_PRDATA  = {8'h77, 8'h00};
        a_PSLVERR = 2'b10;
        a_PREADY  = 2'b10;
        drive_a(1'b0, 9'h1AB, 8'h00, 1'b0);
        qa.push_back('{1'b1, 1'b0, 8'h00, 3, cyc});
        tick();
        a_req_valid = 1'b0;
        tick();
        tick();
        n_chk++;
        if ({a_rsp_valid, a_req_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL err_rsp_cycle got rsp_v=%b rdy=%b exp 1 1", a_rsp_valid, a_req_ready);
        end
        // New request accepted in the response cycle
        drive_a(1'b1, 9'h0F0, 8'h5A, 1'b1);
        qa.push_back('{1'b0, 1'b0, 8'h00, 3, cyc});
        tick();
        a_req_valid = 1'b0;
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_PWRITE, a_PADDR, a_PWDATA} !==
            {2'b01, 1'b0, 1'b1, 9'h0F0, 8'h5A}) begin
            n_err++;
            $display("FAIL b2b_setup got psel=%b pen=%b pw=%b paddr=%h pwd=%h exp 01 0 1 0f0 5a",
                     a_PSEL, a_PENABLE, a_PWRITE, a_PADDR, a_PWDATA);
        end
        a_PREADY = 2'b01;  // PSLVERR[1] stays high and must be ignored
        tick();
        tick();
        n_chk++;
        if (a_rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_done got rsp_v=%b exp 1", a_rsp_valid);
        end
        a_PREADY  = 2'b00;
        a_PSLVERR = 2'b00;
    endtask

    task automatic test_timeout();
        a_PRDATA = {8'h00, 8'h99};
        a_PREADY = 2'b00;
        drive_a(1'b0, 9'h044, 8'h00, 1'b0);
        qa.push_back('{1'b1, 1'b1, 8'h00, 6, cyc});
        tick();
        a_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++;
            if ({a_PSEL, a_PENABLE, a_rsp_valid} !== {2'b01, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL to_wait%0d got psel=%b pen=%b rsp_v=%b exp 01 1 0",
                         k, a_PSEL, a_PENABLE, a_rsp_valid);
            end
        end
        tick();
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_rsp_valid, a_rsp_timeout} !== {2'b00, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL to_exit got psel=%b pen=%b rsp_v=%b to=%b exp 00 0 1 1",
                     a_PSEL, a_PENABLE, a_rsp_valid, a_rsp_timeout);
        end
        tick();
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_rsp_valid, a_rsp_err, a_rsp_timeout} !==
            {2'b00, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL to_hold got psel=%b pen=%b rsp_v=%b err=%b to=%b exp 00 0 0 1 1",
                     a_PSEL, a_PENABLE, a_rsp_valid, a_rsp_err, a_rsp_timeout);
        end
    endtask

    task automatic test_timeout_late_ready();
        a_PREADY = 2'b00;
        drive_a(1'b0, 9'h044, 8'h00, 1'b0);
        qa.push_back('{1'b0, 1'b0, 8'h99, 6, cyc});
        tick();
        a_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        tick();
        a_PREADY = 2'b01;  // ready on the 4th access cycle wins over timeout
        tick();
        n_chk++;
        if ({a_rsp_valid, a_rsp_timeout, a_PSEL} !== {1'b1, 1'b0, 2'b00}) begin
            n_err++;
            $display("FAIL late_ready got rsp_v=%b to=%b psel=%b exp 1 0 00",
                     a_rsp_valid, a_rsp_timeout, a_PSEL);
        end
        a_PREADY = 2'b00;
    endtask

    task automatic test_decode_error();
        b_PRDATA = {8'h42, 8'h00, 8'h00};
        b_PREADY = 3'b100;
        drive_b(1'b0, 9'h140, 8'h00, 1'b0);
        qb.push_back('{1'b0, 1'b0, 8'h42, 3, cyc});
        tick();
        b_req_valid = 1'b0;
        n_chk++;
        if ({b_PSEL, b_PENABLE} !== {3'b100, 1'b0}) begin
            n_err++;
            $display("FAIL b_setup got psel=%b pen=%b exp 100 0", b_PSEL, b_PENABLE);
        end
        tick();
        tick();
        b_PREADY = 3'b111;
        drive_b(1'b1, 9'h1C0, 8'hEE, 1'b1);
        n_chk++;
        if (b_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL dec_ready got %b exp 1", b_req_ready);
        end
        qb.push_back('{1'b1, 1'b0, 8'h00, 1, cyc});
        tick();
        b_req_valid = 1'b0;
        n_chk++;
        if ({b_PSEL, b_PENABLE, b_rsp_valid, b_req_ready, b_PADDR} !==
            {3'b000, 1'b0, 1'b1, 1'b1, 9'h140}) begin
            n_err++;
            $display("FAIL dec_rsp got psel=%b pen=%b rsp_v=%b rdy=%b paddr=%h exp 000 0 1 1 140",
                     b_PSEL, b_PENABLE, b_rsp_valid, b_req_ready, b_PADDR);
        end
        tick();
        n_chk++;
        if ({b_PSEL, b_rsp_valid} !== {3'b000, 1'b0}) begin
            n_err++;
            $display("FAIL dec_after got psel=%b rsp_v=%b exp 000 0", b_PSEL, b_rsp_valid);
        end
        b_PREADY = 3'b000;
    endtask

    task automatic test_reset_mid_access();
        a_PREADY = 2'b00;
        drive_a(1'b1, 9'h1FF, 8'hC3, 1'b1);
        tick();
        a_req_valid = 1'b0;
        tick();
        tick();
        PRESET = 1'b1;
        #1;
        n_chk++;
        if ({a_req_ready, a_PENABLE} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_pre got rdy=%b pen=%b exp 0 1", a_req_ready, a_PENABLE);
        end
        tick();
        n_chk++;
        if ({a_PSEL, a_PENABLE, a_PADDR, a_PWRITE, a_PWDATA, a_PSTRB, a_rsp_valid,
             a_rsp_err, a_rsp_timeout, a_rsp_rdata} !== '0) begin
            n_err++;
            $display("FAIL rst_mid got psel=%b pen=%b paddr=%h pwd=%h rsp_v=%b rdata=%h exp all 0",
                     a_PSEL, a_PENABLE, a_PADDR, a_PWDATA, a_rsp_valid, a_rsp_rdata);
        end
        PRESET = 1'b0;
        #1;
        n_chk++;
        if (a_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_release_ready got %b exp 1", a_req_ready);
        end
        a_PREADY = 2'b10;
        for (int k = 0; k < 3; k++) tick();
        n_chk++;
        if ({a_PSEL, a_PENABLE} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_idle got psel=%b pen=%b exp 00 0", a_PSEL, a_PENABLE);
        end
        a_PREADY = 2'b00;
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slave_error_b2b();
        test_timeout();
        test_timeout_late_ready();
        test_decode_error();
        test_reset_mid_access();
        tick();
        n_chk++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_err++;
            $display("FAIL missing_rsp got pending a=%0d b=%0d exp 0 0", qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
